// File: rtl/cmd_queue_pkg.sv
// Command word layout shared by the host, cmd_queue and the issuer.
package cmd_queue_pkg;

   typedef struct packed {
      logic [3:0]  op;
      logic [11:0] arg;
   } cmd_t;

endpackage

// File: rtl/cmd_queue.sv
// FWFT command FIFO feeding the issuer, with a popped-but-unfinished task
// counter and sticky protocol-error flags.
module cmd_queue #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned CMD_W   = $bits(cmd_queue_pkg::cmd_t),
   parameter int unsigned HIGH_WM = 12,
   parameter int unsigned OUT_W   = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_push_valid,
   input  logic [CMD_W-1:0]         i_push_cmd,
   output logic                     o_push_ready,
   input  logic                     i_flush,
   output logic [CMD_W-1:0]         o_cmd,
   output logic                     o_empty,
   input  logic                     i_rd,
   input  logic                     i_finished_task,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_high_water,
   output logic [OUT_W-1:0]         o_outstanding,
   output logic                     o_done,
   output logic [1:0]               o_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [1:0]       err_q, err_d;

   logic full, empty, push, pop;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
   assign empty = (wp_q == rp_q);
   assign push  = i_push_valid && !full;
   assign pop   = i_rd && !empty;

   // Next-state for pointers, outstanding counter and sticky errors.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      out_d = out_q;
      err_d = err_q;
      if (i_flush) begin
         wp_d  = '0;
         rp_d  = '0;
         out_d = '0;
         err_d = '0;
      end else begin
         if (push) wp_d = wp_q + PW'(1);
         if (pop)  rp_d = rp_q + PW'(1);
         if (i_rd && empty) err_d[0] = 1'b1;
         if (pop && !i_finished_task) begin
            if (out_q != OUT_MAX) out_d = out_q + OUT_W'(1);
         end else if (!pop && i_finished_task) begin
            if (out_q == '0) err_d[1] = 1'b1;
            else             out_d = out_q - OUT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wp_q  <= '0;
         rp_q  <= '0;
         out_q <= '0;
         err_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   // Storage has no reset; flush and reset only move the pointers.
   always_ff @(posedge i_clk) begin
      if (push && !i_flush) mem_q[wp_q[AW-1:0]] <= i_push_cmd;
   end

   assign o_cmd         = empty ? '0 : mem_q[rp_q[AW-1:0]];
   assign o_empty       = empty;
   assign o_push_ready  = !full;
   assign o_count       = wp_q - rp_q;
   assign o_high_water  = (o_count >= PW'(HIGH_WM));
   assign o_outstanding = out_q;
   assign o_done        = empty && (out_q == '0);
   assign o_err         = err_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed checks of cmd_queue: ordering, full/hold, outstanding counter,
// error flags, flush priority and a wrapped overlapping push/pop stream.
module tb_cmd_queue;

   logic        i_clk;
   logic        i_rstn;
   logic        i_push_valid;
   logic [15:0] i_push_cmd;
   logic        o_push_ready;
   logic        i_flush;
   logic [15:0] o_cmd;
   logic        o_empty;
   logic        i_rd;
   logic        i_finished_task;
   logic [4:0]  o_count;
   logic        o_high_water;
   logic [7:0]  o_outstanding;
   logic        o_done;
   logic [1:0]  o_err;

   int checks = 0;
   int errors = 0;

   cmd_queue dut (
      .i_clk           (i_clk),
      .i_rstn          (i_rstn),
      .i_push_valid    (i_push_valid),
      .i_push_cmd      (i_push_cmd),
      .o_push_ready    (o_push_ready),
      .i_flush         (i_flush),
      .o_cmd           (o_cmd),
      .o_empty         (o_empty),
      .i_rd            (i_rd),
      .i_finished_task (i_finished_task),
      .o_count         (o_count),
      .o_high_water    (o_high_water),
      .o_outstanding   (o_outstanding),
      .o_done          (o_done),
      .o_err           (o_err)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   logic [15:0] model_q[$];
   logic [15:0] exp_w;
   int          sent;
   int          rcvd;
   int          cyc;
   logic        do_push;
   logic        do_pop;

   initial begin
      i_rstn = 1'b0;
      i_push_valid = 1'b0;
      i_push_cmd = '0;
      i_flush = 1'b0;
      i_rd = 1'b0;
      i_finished_task = 1'b0;
      #3;
      chk("rst_ready", 32'(o_push_ready), 32'd1);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_cmd", 32'(o_cmd), 32'd0);
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_hw", 32'(o_high_water), 32'd0);
      chk("rst_out", 32'(o_outstanding), 32'd0);
      chk("rst_done", 32'(o_done), 32'd1);
      chk("rst_err", 32'(o_err), 32'd0);
      #10 i_rstn = 1'b1;
      step();

      // Three pushes, then pops and finish pulses on the outstanding counter.
      i_push_valid = 1'b1;
      i_push_cmd = 16'h000A; step();
      chk("push1_count", 32'(o_count), 32'd1);
      chk("push1_cmd", 32'(o_cmd), 32'h000A);
      chk("push1_done", 32'(o_done), 32'd0);
      i_push_cmd = 16'h000B; step();
      chk("push2_count", 32'(o_count), 32'd2);
      i_push_cmd = 16'h000C; step();
      chk("push3_count", 32'(o_count), 32'd3);
      chk("push3_head", 32'(o_cmd), 32'h000A);
      i_push_valid = 1'b0;
      i_rd = 1'b1; step();
      chk("pop1_cmd", 32'(o_cmd), 32'h000B);
      chk("pop1_out", 32'(o_outstanding), 32'd1);
      step();
      chk("pop2_cmd", 32'(o_cmd), 32'h000C);
      chk("pop2_out", 32'(o_outstanding), 32'd2);
      i_rd = 1'b0;
      i_finished_task = 1'b1; step();
      chk("fin1_out", 32'(o_outstanding), 32'd1);
      i_rd = 1'b1; step();
      chk("finrd_out", 32'(o_outstanding), 32'd1);
      chk("finrd_empty", 32'(o_empty), 32'd1);
      chk("finrd_cmd", 32'(o_cmd), 32'd0);
      chk("finrd_done", 32'(o_done), 32'd0);
      i_rd = 1'b0; step();
      chk("fin2_out", 32'(o_outstanding), 32'd0);
      chk("fin2_done", 32'(o_done), 32'd1);
      i_finished_task = 1'b0;

      // Error flags are sticky until flush.
      i_rd = 1'b1; step(); i_rd = 1'b0;
      chk("rdempty_err", 32'(o_err), 32'd1);
      chk("rdempty_count", 32'(o_count), 32'd0);
      chk("rdempty_out", 32'(o_outstanding), 32'd0);
      i_finished_task = 1'b1; step(); i_finished_task = 1'b0;
      chk("fin0_err", 32'(o_err), 32'd3);
      chk("fin0_out", 32'(o_outstanding), 32'd0);
      step(); step();
      chk("err_sticky", 32'(o_err), 32'd3);
      i_flush = 1'b1; step(); i_flush = 1'b0;
      chk("flush_err", 32'(o_err), 32'd0);

      // Fill to DEPTH, hold a 17th offer, then pop with the push still held.
      i_push_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         i_push_cmd = 16'(16'h0100 + i);
         step();
         if (i == 10) chk("hw_at11", 32'(o_high_water), 32'd0);
         if (i == 11) chk("hw_at12", 32'(o_high_water), 32'd1);
      end
      chk("full_ready", 32'(o_push_ready), 32'd0);
      chk("full_count", 32'(o_count), 32'd16);
      i_push_cmd = 16'h01FF; step();
      chk("held_count", 32'(o_count), 32'd16);
      chk("held_head", 32'(o_cmd), 32'h0100);
      i_rd = 1'b1; step(); i_rd = 1'b0;
      chk("poppush_count", 32'(o_count), 32'd15);
      chk("poppush_cmd", 32'(o_cmd), 32'h0101);
      step(); i_push_valid = 1'b0;
      chk("held_accept_count", 32'(o_count), 32'd16);
      chk("held_accept_ready", 32'(o_push_ready), 32'd0);
      for (int i = 0; i < 16; i++) begin
         i_rd = 1'b1; step();
      end
      i_rd = 1'b0;
      chk("tail_popped_count", 32'(o_count), 32'd0);
      i_flush = 1'b1; step(); i_flush = 1'b0;

      // Flush priority over same-cycle push and pop.
      i_rd = 1'b1; step(); i_rd = 1'b0;
      chk("pre_flush_err", 32'(o_err), 32'd1);
      i_push_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_push_cmd = 16'(16'h0300 + i);
         step();
      end
      i_push_valid = 1'b0;
      i_rd = 1'b1; step(); step(); step(); i_rd = 1'b0;
      chk("pre_flush_count", 32'(o_count), 32'd5);
      chk("pre_flush_out", 32'(o_outstanding), 32'd3);
      i_flush = 1'b1; i_push_valid = 1'b1; i_push_cmd = 16'h0FFF; i_rd = 1'b1;
      step();
      i_flush = 1'b0; i_push_valid = 1'b0; i_rd = 1'b0;
      chk("flush_count", 32'(o_count), 32'd0);
      chk("flush_out", 32'(o_outstanding), 32'd0);
      chk("flush_err2", 32'(o_err), 32'd0);
      chk("flush_empty", 32'(o_empty), 32'd1);
      chk("flush_done", 32'(o_done), 32'd1);

      // Overlapping random push/pop stream of 40 words across pointer wraps.
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      while (rcvd < 40 && cyc < 2000) begin
         do_push = (sent < 40) && ($urandom_range(0, 99) < 60);
         do_pop  = (model_q.size() > 0) && ($urandom_range(0, 99) < 50);
         i_push_valid = do_push;
         i_push_cmd   = 16'($urandom_range(0, 65535));
         i_rd         = do_pop;
         chk("strm_count", 32'(o_count), 32'(model_q.size()));
         chk("strm_ready", 32'(o_push_ready), 32'(model_q.size() < 16));
         if (do_pop) begin
            exp_w = model_q.pop_front();
            chk("strm_cmd", 32'(o_cmd), 32'(exp_w));
            rcvd++;
         end
         if (do_push && (model_q.size() + (do_pop ? 1 : 0)) < 16) begin
            model_q.push_back(i_push_cmd);
            sent++;
         end
         step();
         cyc++;
      end
      i_push_valid = 1'b0;
      i_rd = 1'b0;
      chk("strm_complete", 32'(rcvd), 32'd40);
      chk("strm_end_empty", 32'(o_empty), 32'd1);

      // Asynchronous reset mid-operation.
      i_push_valid = 1'b1; i_push_cmd = 16'h0777; step();
      #2 i_rstn = 1'b0;
      #1;
      chk("async_rst_count", 32'(o_count), 32'd0);
      chk("async_rst_out", 32'(o_outstanding), 32'd0);
      i_push_valid = 1'b0;
      #10 i_rstn = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmd_queue.md
# cmd_queue

Command FIFO that sits directly upstream of the issuer. The host or testbench pushes `cmd_t` words through a valid/ready port. The issuer pops them through a first-word-fall-through (FWFT) port that matches its `i_cmd` / `i_empty_queue` / `o_rd_queue` interface. The block also counts commands popped but not yet reported finished, so the system can raise one "all work done" flag.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two, ≥2.
- `CMD_W`, `$bits(cmd_t)`: width of one command word.
- `HIGH_WM`, 12: occupancy threshold for `o_high_water`; range 1..DEPTH.
- `OUT_W`, 8: width of the outstanding-task counter.

Ports:
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_push_valid`  in  1  host offers `i_push_cmd`.
- `i_push_cmd`  in  CMD_W  command word.
- `o_push_ready`  out  1  queue can accept a push this cycle.
- `i_flush`  in  1  synchronous clear of queue contents and status.
- `o_cmd`  out  CMD_W  head entry (FWFT); connects to issuer `i_cmd`.
- `o_empty`  out  1  queue empty; connects to issuer `i_empty_queue`.
- `i_rd`  in  1  pop strobe; connects to issuer `o_rd_queue`.
- `i_finished_task`  in  1  one-cycle pulse per completed task; connects to issuer `o_finished_task`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_high_water`  out  1  `o_count >= HIGH_WM`.
- `o_outstanding`  out  OUT_W  commands popped but not yet finished.
- `o_done`  out  1  `o_empty && o_outstanding==0`.
- `o_err`  out  2  sticky errors: bit0 = pop while empty; bit1 = finish pulse with outstanding==0.

## Operation
- Storage is a register array indexed by write and read pointers of width $clog2(DEPTH)+1. The extra MSB is the wrap bit.
- Full when the low pointer bits are equal and the MSBs differ. Empty when both pointers are equal.
- Push: occurs when `i_push_valid && o_push_ready`. Writes `mem[wp]` and increments `wp`.
- `o_push_ready = !full`. This is computed from the current state only; a same-cycle pop does not make room for a push.
- Holding `i_push_valid` while not ready is legal. The word is not accepted, and the host must hold it.
- Pop: occurs when `i_rd && !o_empty`. Increments `rp` and increments `o_outstanding`.
- `i_rd` while empty is ignored and sets `o_err[0]`.
- `o_cmd = mem[rp]` when not empty; it is all-zero when empty.
- Simultaneous push and pop when neither full nor empty: both happen, and `o_count` is unchanged.
- Outstanding counter:
  - Pop alone: +1.
  - `i_finished_task` alone: −1.
  - Both in the same cycle: unchanged.
  - A finish pulse at 0 is ignored and sets `o_err[1]`.
  - The counter saturates at 2^OUT_W−1 and never wraps.
- Flush:
  - Resets `wp`, `rp`, `o_outstanding` and `o_err` to 0.
  - Has priority over a push, pop or finish in the same cycle; those same-cycle events are discarded.
  - Memory contents are not cleared.
- Reset mid-operation: all state returns to its reset values immediately (asynchronous). Any in-flight push is lost.

## Timing
- Reset values of outputs:
  - `o_push_ready=1`, `o_empty=1`, `o_cmd=0`, `o_count=0`.
  - `o_high_water=0`, `o_outstanding=0`, `o_done=1`, `o_err=0`.
- Push-to-visible latency is 1 cycle. A word accepted at edge N appears on `o_cmd` with `o_empty=0` after edge N.
- Pop takes effect at the edge. After that edge, `o_cmd` shows the next entry, or zero and `o_empty=1` if the queue is now empty.
- The issuer can sample `o_cmd` in the same cycle it asserts `i_rd` (FWFT). There is no read latency.
- `o_count`, `o_high_water`, `o_done` and `o_push_ready` are derived combinationally from registered pointers and counters. They carry no extra delay.
- Back-to-back pushes and pops are sustained at 1 per cycle each.
- Pointer wrap-around is seamless. There is no bubble at the DEPTH boundary.

## Test plan
- Reset, then push 3 words (0xA, 0xB, 0xC) on consecutive cycles -> `o_count` reads 1, 2, 3. `o_cmd=0xA` from the cycle after the first push. `o_done=0`.
- Push 16 words (DEPTH=16) -> `o_push_ready=0` and `o_count=16`. `o_high_water` goes high after the 12th push. A 17th offer is held and not accepted. A pop plus a held push in the same cycle: pop only. The push is accepted on the next cycle.
- Fill and drain 40 words with random overlapping push/pop streams (wraps the pointers twice) -> output order is identical to input order, with no loss or duplication.
- Pop 2 commands, then pulse `i_finished_task`, then pulse `i_finished_task` and `i_rd` in the same cycle with the queue holding 1 word -> `o_outstanding` reads 2, 1, 1. After a final finish pulse, `o_done=1`.
- `i_rd` while empty -> no pointer change, `o_err=01`. A finish pulse at outstanding 0 -> `o_err=11`. Both bits stay set until `i_flush`.
- With 5 queued words and 3 outstanding, assert `i_flush` together with `i_push_valid` and `i_rd` -> next cycle `o_count=0`, `o_outstanding=0`, `o_err=0`, `o_empty=1`, `o_done=1`.
